clb_cfg_loader: RTL and testbench

- Serial configuration loader: the writer side of the CLB configuration state.
- Receives a serial bitstream, detects the preamble, and assembles 37-bit CLB configuration frames.
- Checks parity on each frame, then presents the frame in parallel with a write strobe and a frame address, so an array of CLBs can be configured at power-up.
- Sits between the external configuration pin and the CLB array configuration storage.

---
 rtl/clb_cfg_pkg.sv | 40 ++++
 rtl/clb_cfg_shift.sv | 53 +++++
 rtl/clb_cfg_loader.sv | 110 +++++++++++
 tb/tb_clb_cfg_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader: frame field layout,
// preamble pattern and loader FSM states.
package clb_cfg_pkg;

    localparam int CFG_W = 37;

    localparam int LUT_MSB   = 36;
    localparam int LUT_LSB   = 21;
    localparam int COMB_MSB  = 20;
    localparam int COMB_LSB  = 19;
    localparam int MUX2_MSB  = 18;
    localparam int MUX2_LSB  = 17;
    localparam int MUX3_MSB  = 16;
    localparam int MUX3_LSB  = 15;
    localparam int MUX4_MSB  = 14;
    localparam int MUX4_LSB  = 13;
    localparam int MUX5_MSB  = 12;
    localparam int MUX5_LSB  = 11;
    localparam int MUX6_MSB  = 10;
    localparam int MUX6_LSB  = 9;
    localparam int O2M0_MSB  = 8;
    localparam int O2M0_LSB  = 6;
    localparam int O2M1_MSB  = 5;
    localparam int O2M1_LSB  = 3;
    localparam int DQMUX_MSB = 2;
    localparam int DQMUX_LSB = 1;
    localparam int FLOP_MSB  = 0;
    localparam int FLOP_LSB  = 0;

    localparam logic [3:0] PREAMBLE = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAR,
        ST_DONE,
        ST_ERR
    } cfg_state_e;

endpackage

// File: rtl/clb_cfg_shift.sv
// Frame assembly shift register with running parity and bit counter.
module clb_cfg_shift
    import clb_cfg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             din_i,
    output logic [CFG_W-1:0] data_o,
    output logic             frame_full_o,
    output logic             parity_ok_o
);

    localparam int CW = $clog2(CFG_W + 1);

    logic [CFG_W-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        par_d  = par_q;
        if (clr_i) begin
            data_d = '0;
            cnt_d  = '0;
            par_d  = 1'b0;
        end else if (shift_i) begin
            data_d = {data_q[CFG_W-2:0], din_i};
            cnt_d  = cnt_q + CW'(1);
            par_d  = par_q ^ din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            cnt_q  <= '0;
            par_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            par_q  <= par_d;
        end
    end

    assign data_o = data_q;
    // Flags the shift that completes the frame, so the next valid bit is already parity.
    assign frame_full_o = shift_i && (cnt_q == CW'(CFG_W - 1));
    assign parity_ok_o  = ~(par_q ^ din_i);

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: preamble detect, frame assembly, parity check
// and per-frame write strobe into the CLB array configuration storage.
//
// state   | meaning
// IDLE    | hunting for preamble 0010 on the idle-high line
// DATA    | shifting the 37 frame bits, MSB first
// PAR     | next valid bit is the even-parity bit
// DONE    | all frames written; terminal until reset
// ERR     | parity failure; terminal until reset
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int FRAMES = 4,
    parameter int AW     = 2
) (
    input  logic             K,
    input  logic             RSTN,
    input  logic             DIN,
    input  logic             DIN_VALID,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_WE,
    output logic [AW-1:0]    FRAME_ADDR,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    cfg_state_e       state_q, state_d;
    logic [3:0]       pre_q, pre_d;
    logic [AW-1:0]    fcnt_q, fcnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             we_q, we_d;

    logic             sh_clr, sh_en, frame_full, parity_ok;
    logic [CFG_W-1:0] sh_data;

    assign sh_en  = DIN_VALID && (state_q == ST_DATA);
    // The shifter restarts right after the parity sample so frames can run back-to-back.
    assign sh_clr = (state_q != ST_DATA) && !((state_q == ST_PAR) && !DIN_VALID);

    clb_cfg_shift u_shift (
        .clk_i        (K),
        .rst_n_i      (RSTN),
        .clr_i        (sh_clr),
        .shift_i      (sh_en),
        .din_i        (DIN),
        .data_o       (sh_data),
        .frame_full_o (frame_full),
        .parity_ok_o  (parity_ok)
    );

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        fcnt_d  = fcnt_q;
        addr_d  = addr_q;
        cfg_d   = cfg_q;
        we_d    = 1'b0;
        if (DIN_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    pre_d = {pre_q[2:0], DIN};
                    if (pre_d == PREAMBLE) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (frame_full) state_d = ST_PAR;
                end
                ST_PAR: begin
                    if (parity_ok) begin
                        we_d    = 1'b1;
                        cfg_d   = sh_data;
                        addr_d  = fcnt_q;
                        fcnt_d  = fcnt_q + AW'(1);
                        state_d = (fcnt_q == AW'(FRAMES - 1)) ? ST_DONE : ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge K or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            pre_q   <= 4'b1111;
            fcnt_q  <= '0;
            addr_q  <= '0;
            cfg_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            fcnt_q  <= fcnt_d;
            addr_q  <= addr_d;
            cfg_q   <= cfg_d;
            we_q    <= we_d;
        end
    end

    assign CFG        = cfg_q;
    assign CFG_WE     = we_q;
    assign FRAME_ADDR = addr_q;
    assign BUSY       = (state_q == ST_DATA) || (state_q == ST_PAR);
    assign DONE       = (state_q == ST_DONE);
    assign ERR        = (state_q == ST_ERR);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Bench for clb_cfg_loader: streams are built up front, a stream-level model
// derives expected outputs per cycle, and two DUTs (FRAMES=1 and FRAMES=4) are checked.
module tb_clb_cfg_loader;
    import clb_cfg_pkg::*;

    localparam int MAXC = 2048;

    logic K = 1'b0;
    logic RSTN = 1'b0;
    logic DIN = 1'b1;
    logic DIN_VALID = 1'b0;

    logic [36:0] cfg1, cfg4;
    logic        we1, we4, busy1, busy4, done1, done4, err1, err4;
    logic [1:0]  addr1, addr4;

    clb_cfg_loader #(.FRAMES(1), .AW(2)) dut1 (
        .K(K), .RSTN(RSTN), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .CFG(cfg1), .CFG_WE(we1), .FRAME_ADDR(addr1),
        .BUSY(busy1), .DONE(done1), .ERR(err1)
    );

    clb_cfg_loader #(.FRAMES(4), .AW(2)) dut4 (
        .K(K), .RSTN(RSTN), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .CFG(cfg4), .CFG_WE(we4), .FRAME_ADDR(addr4),
        .BUSY(busy4), .DONE(done4), .ERR(err4)
    );

    always #5 K = ~K;

    logic s_din[$];
    logic s_vld[$];
    logic s_rst[$];

    logic [36:0] e_cfg  [2][MAXC];
    logic        e_we   [2][MAXC];
    logic [1:0]  e_addr [2][MAXC];
    logic        e_busy [2][MAXC];
    logic        e_done [2][MAXC];
    logic        e_err  [2][MAXC];
    int          stb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, int t, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, t, act, exp);
        end
    endtask

    function automatic void push(logic d, logic v, logic r);
        s_din.push_back(d);
        s_vld.push_back(v);
        s_rst.push_back(r);
    endfunction

    // mode 0: no stalls, 1: one stall after every valid bit, 2: random stalls
    function automatic void push_bit(logic d, int mode);
        if (mode == 2)
            while ($urandom_range(0, 99) < 30) push(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        push(d, 1'b1, 1'b1);
        if (mode == 1) push(~d, 1'b0, 1'b1);
    endfunction

    function automatic void push_idle(int n, int mode);
        for (int i = 0; i < n; i++) push_bit(1'b1, mode);
    endfunction

    function automatic void push_pre(int mode);
        logic [3:0] p;
        p = PREAMBLE;
        for (int i = 3; i >= 0; i--) push_bit(p[i], mode);
    endfunction

    function automatic void push_frame(logic [36:0] f, logic flip, int mode);
        for (int i = 36; i >= 0; i--) push_bit(f[i], mode);
        push_bit((^f) ^ flip, mode);
    endfunction

    function automatic void push_partial(logic [36:0] f, int nbits);
        for (int i = 36; i > 36 - nbits; i--) push_bit(f[i], 0);
    endfunction

    function automatic void begin_stream();
        s_din.delete();
        s_vld.delete();
        s_rst.delete();
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
    endfunction

    // Stream-level reference: count valid bits after the preamble and cut them into 38-bit frames.
    function automatic void model(int di, int frames);
        logic [3:0]  pre;
        logic        started, fin, bad, we;
        logic [36:0] sh, cfg;
        logic [1:0]  addr;
        int          k, fidx;
        pre = 4'hF; started = 0; fin = 0; bad = 0; sh = '0; cfg = '0; addr = '0; k = 0; fidx = 0;
        for (int t = 0; t < s_din.size(); t++) begin
            we = 1'b0;
            if (!s_rst[t]) begin
                pre = 4'hF; started = 0; fin = 0; bad = 0; sh = '0; cfg = '0; addr = '0;
                k = 0; fidx = 0;
            end else if (s_vld[t] && !fin && !bad) begin
                if (!started) begin
                    pre = {pre[2:0], s_din[t]};
                    started = (pre == PREAMBLE);
                    k = 0;
                end else if ((k % 38) < 37) begin
                    sh = {sh[35:0], s_din[t]};
                    k++;
                end else begin
                    k++;
                    if ((^sh) == s_din[t]) begin
                        cfg = sh;
                        addr = fidx[1:0];
                        we = 1'b1;
                        fidx++;
                        fin = (fidx == frames);
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            e_cfg[di][t]  = cfg;
            e_we[di][t]   = we;
            e_addr[di][t] = addr;
            e_busy[di][t] = started && !fin && !bad;
            e_done[di][t] = fin;
            e_err[di][t]  = bad;
        end
    endfunction

    function automatic void find_strobes(int di);
        stb.delete();
        for (int t = 0; t < s_din.size(); t++)
            if (e_we[di][t]) stb.push_back(t);
    endfunction

    task automatic cmp_cycle(int t);
        chk("d1_cfg",  t, 64'(cfg1),  64'(e_cfg[0][t]));
        chk("d1_we",   t, 64'(we1),   64'(e_we[0][t]));
        chk("d1_addr", t, 64'(addr1), 64'(e_addr[0][t]));
        chk("d1_busy", t, 64'(busy1), 64'(e_busy[0][t]));
        chk("d1_done", t, 64'(done1), 64'(e_done[0][t]));
        chk("d1_err",  t, 64'(err1),  64'(e_err[0][t]));
        chk("d4_cfg",  t, 64'(cfg4),  64'(e_cfg[1][t]));
        chk("d4_we",   t, 64'(we4),   64'(e_we[1][t]));
        chk("d4_addr", t, 64'(addr4), 64'(e_addr[1][t]));
        chk("d4_busy", t, 64'(busy4), 64'(e_busy[1][t]));
        chk("d4_done", t, 64'(done4), 64'(e_done[1][t]));
        chk("d4_err",  t, 64'(err4),  64'(e_err[1][t]));
    endtask

    task automatic run_stream();
        logic was;
        model(0, 1);
        model(1, 4);
        for (int t = 0; t < s_din.size(); t++) begin
            was = RSTN;
            DIN = s_din[t];
            DIN_VALID = s_vld[t];
            RSTN = s_rst[t];
            if (was && !RSTN) begin
                #1;
                chk("async_rst_d4", t, {cfg4, we4, addr4, busy4, done4, err4}, 64'd0);
                chk("async_rst_d1", t, {cfg1, we1, addr1, busy1, done1, err1}, 64'd0);
            end
            @(posedge K);
            @(negedge K);
            cmp_cycle(t);
        end
    endtask

    initial begin
        // Test 1: single frame, FRAMES=1 DUT completes
        begin_stream();
        push_idle(8, 0);
        push_pre(0);
        push_frame(37'h0_22C5_4038, 1'b0, 0);
        push_idle(5, 0);
        run_stream();
        find_strobes(0);
        chk("t1_nstrobe", 0, stb.size(), 1);
        if (stb.size() == 1) begin
            chk("t1_strobe_cyc", 0, stb[0], 51);
            chk("t1_cfg", stb[0], e_cfg[0][stb[0]], 37'h0_22C5_4038);
            chk("t1_done", stb[0], e_done[0][stb[0]], 1);
        end

        // Test 2: four back-to-back frames
        begin_stream();
        push_idle(8, 0);
        push_pre(0);
        push_frame(37'h0_0000_0001, 1'b0, 0);
        push_frame(37'h0_0000_0003, 1'b0, 0);
        push_frame(37'h1F_FFFF_FFFF, 1'b0, 0);
        push_frame(37'h0, 1'b0, 0);
        push_idle(5, 0);
        run_stream();
        find_strobes(1);
        chk("t2_nstrobe", 0, stb.size(), 4);
        if (stb.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_strobe_cyc", i, stb[i], 51 + 38 * i);
                chk("t2_addr", i, e_addr[1][stb[i]], i);
            end
            chk("t2_cfg2", 2, e_cfg[1][stb[2]], 37'h1F_FFFF_FFFF);
            chk("t2_done_early", 2, e_done[1][stb[2]], 0);
            chk("t2_done_last", 3, e_done[1][stb[3]], 1);
        end

        // Test 3: parity error on frame 1, later frames ignored
        begin_stream();
        push_idle(8, 0);
        push_pre(0);
        push_frame(37'h0_1234_5678, 1'b0, 0);
        push_frame(37'h1_0F0F_0F0F, 1'b1, 0);
        push_frame(37'h0_0000_0001, 1'b0, 0);
        push_frame(37'h0_0000_0003, 1'b0, 0);
        push_idle(3, 0);
        run_stream();
        find_strobes(1);
        chk("t3_nstrobe", 0, stb.size(), 1);
        chk("t3_err", s_din.size() - 1, e_err[1][s_din.size() - 1], 1);
        chk("t3_busy", s_din.size() - 1, e_busy[1][s_din.size() - 1], 0);

        // Test 4: test 1 with a stall after every valid cycle
        begin_stream();
        push_idle(8, 1);
        push_pre(1);
        push_frame(37'h0_22C5_4038, 1'b0, 1);
        push_idle(3, 1);
        run_stream();
        find_strobes(0);
        chk("t4_nstrobe", 0, stb.size(), 1);
        if (stb.size() == 1) begin
            chk("t4_strobe_cyc", 0, stb[0], 100);
            chk("t4_cfg", stb[0], e_cfg[0][stb[0]], 37'h0_22C5_4038);
        end

        // Test 5: reset mid-frame, then a fresh load restarts at address 0
        begin_stream();
        push_idle(8, 0);
        push_pre(0);
        push_frame(37'h0_ABCD_1234, 1'b0, 0);
        push_partial(37'h1_5555_AAAA, 20);
        push(1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b0);
        push_idle(3, 0);
        push_pre(0);
        push_frame(37'h1_0000_8001, 1'b0, 0);
        push_idle(3, 0);
        run_stream();
        find_strobes(1);
        chk("t5_nstrobe", 0, stb.size(), 2);
        if (stb.size() == 2) begin
            chk("t5_strobe_cyc", 1, stb[1], 118);
            chk("t5_addr", 1, e_addr[1][stb[1]], 0);
        end

        // Test 6: preamble pattern inside frame data
        begin_stream();
        push_idle(8, 0);
        push_pre(0);
        push_frame(37'h0_4123_4567, 1'b0, 0);
        push_idle(3, 0);
        run_stream();
        find_strobes(0);
        chk("t6_nstrobe", 0, stb.size(), 1);
        if (stb.size() == 1) chk("t6_cfg", stb[0], e_cfg[0][stb[0]], 37'h0_4123_4567);

        // Randomized streams: random idle validity, stalls, payloads and rare parity faults
        for (int r = 0; r < 6; r++) begin
            begin_stream();
            repeat ($urandom_range(0, 10)) push(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            push_pre(2);
            for (int f = 0; f < 4; f++)
                push_frame({5'($urandom), 32'($urandom)}, ($urandom_range(0, 9) == 0), 2);
            push_idle(4, 2);
            run_stream();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
